plru_tracker: RTL and testbench

Per-set tree pseudo-LRU replacement-state tracker for the set-associative caches. The cache controller records every hit and refill as a "touch" here, and queries a set to get its least-recently-used victim way. `replace_way_gen` selects a victim from random state. This block is the recording counterpart: it writes usage history and reads back a deterministic victim. Sits beside the tag/valid arrays; the controller may use it in place of the random generator when every way of a set is valid.

---
 rtl/plru_tracker.sv | 102 ++++++++++
 tb/tb_plru_tracker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plru_tracker.sv
// Per-set tree pseudo-LRU tracker: touches record usage, lookups return a one-hot victim one cycle later.
// Optional macro PLRU_BYPASS_EN forwards a same-cycle, same-index touch into the lookup.
module plru_tracker #(
    parameter  int NUM_WAY = 2,
    parameter  int NUM_SET = 64,
    localparam int IDX_W   = $clog2(NUM_SET),
    localparam int TREE_W  = NUM_WAY - 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               lookup_valid,
    input  logic [IDX_W-1:0]   lookup_index,
    input  logic               touch_valid,
    input  logic [IDX_W-1:0]   touch_index,
    input  logic [NUM_WAY-1:0] touch_way,
    output logic               victim_valid,
    output logic [NUM_WAY-1:0] victim_way
);
    localparam int LVL = $clog2(NUM_WAY);

    logic [TREE_W-1:0]  r_tree [NUM_SET];
    logic               r_victim_valid;
    logic [NUM_WAY-1:0] r_victim_way;

    logic               w_touch_hit;
    logic [LVL-1:0]     w_touch_wid;
    logic [TREE_W-1:0]  w_touch_cur;
    logic [TREE_W-1:0]  w_touch_upd;
    logic [TREE_W-1:0]  w_lk_tree;
    logic [NUM_WAY-1:0] w_victim;

    // Lowest set bit of touch_way wins; scanning downward leaves it last.
    always_comb begin : touch_select
        w_touch_hit = 1'b0;
        w_touch_wid = '0;
        for (int k = NUM_WAY - 1; k >= 0; k--) begin
            if (touch_way[k]) begin
                w_touch_hit = 1'b1;
                w_touch_wid = LVL'(k);
            end
        end
    end

    always_comb begin : touch_update
        int v_node;
        int v_parent;
        v_parent    = 0;
        w_touch_cur = r_tree[touch_index];
        w_touch_upd = w_touch_cur;
        v_node      = int'(w_touch_wid) + TREE_W;
        // Climb leaf->root; an odd node is a left child, so its parent must point right.
        for (int l = 0; l < LVL; l++) begin
            v_parent = (v_node - 1) / 2;
            if (v_node[0])
                w_touch_upd = w_touch_upd | (TREE_W'(1) << v_parent);
            else
                w_touch_upd = w_touch_upd & ~(TREE_W'(1) << v_parent);
            v_node = v_parent;
        end
    end

    always_comb begin : victim_walk
        int                v_node;
        logic [TREE_W-1:0] v_sh;
        v_sh      = '0;
        w_lk_tree = r_tree[lookup_index];
`ifdef PLRU_BYPASS_EN
        if (touch_valid && w_touch_hit && (touch_index == lookup_index))
            w_lk_tree = w_touch_upd;
`else
`endif
        v_node = 0;
        for (int l = 0; l < LVL; l++) begin
            v_sh   = w_lk_tree >> v_node;
            v_node = 2 * v_node + 1 + int'(v_sh[0]);
        end
        w_victim = NUM_WAY'(1) << (v_node - TREE_W);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < NUM_SET; s++)
                r_tree[s] <= '0;
        end else if (touch_valid && w_touch_hit) begin
            r_tree[touch_index] <= w_touch_upd;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_victim_valid <= 1'b0;
            r_victim_way   <= NUM_WAY'(1);
        end else begin
            r_victim_valid <= lookup_valid;
            if (lookup_valid)
                r_victim_way <= w_victim;
        end
    end

    assign victim_valid = r_victim_valid;
    assign victim_way   = r_victim_way;
endmodule

// File: tb/tb_plru_tracker.sv
// Directed bench for plru_tracker: a 4-way/64-set instance and a 2-way/2-set instance.
module tb_plru_tracker;
    logic       clk;
    logic       resetn;

    logic       lk_valid4, tc_valid4;
    logic [5:0] lk_idx4, tc_idx4;
    logic [3:0] tc_way4;
    logic       vv4;
    logic [3:0] vw4;

    logic       lk_valid2, tc_valid2;
    logic [0:0] lk_idx2, tc_idx2;
    logic [1:0] tc_way2;
    logic       vv2;
    logic [1:0] vw2;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef PLRU_BYPASS_EN
    localparam logic [3:0] EXP_SAME_CYCLE = 4'b0100;
`else
    localparam logic [3:0] EXP_SAME_CYCLE = 4'b0001;
`endif

    plru_tracker #(.NUM_WAY(4), .NUM_SET(64)) u_dut4 (
        .clk(clk), .resetn(resetn),
        .lookup_valid(lk_valid4), .lookup_index(lk_idx4),
        .touch_valid(tc_valid4), .touch_index(tc_idx4), .touch_way(tc_way4),
        .victim_valid(vv4), .victim_way(vw4)
    );

    plru_tracker #(.NUM_WAY(2), .NUM_SET(2)) u_dut2 (
        .clk(clk), .resetn(resetn),
        .lookup_valid(lk_valid2), .lookup_index(lk_idx2),
        .touch_valid(tc_valid2), .touch_index(tc_idx2), .touch_way(tc_way2),
        .victim_valid(vv2), .victim_way(vw2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic touch4(input logic [5:0] idx, input logic [3:0] way);
        @(negedge clk);
        tc_valid4 = 1'b1; tc_idx4 = idx; tc_way4 = way;
        @(negedge clk);
        tc_valid4 = 1'b0; tc_way4 = '0;
    endtask

    task automatic lookup4(input logic [5:0] idx, output logic vv, output logic [3:0] vw);
        @(negedge clk);
        lk_valid4 = 1'b1; lk_idx4 = idx;
        @(negedge clk);
        lk_valid4 = 1'b0;
        vv = vv4; vw = vw4;
    endtask

    task automatic touch2(input logic [0:0] idx, input logic [1:0] way);
        @(negedge clk);
        tc_valid2 = 1'b1; tc_idx2 = idx; tc_way2 = way;
        @(negedge clk);
        tc_valid2 = 1'b0; tc_way2 = '0;
    endtask

    task automatic lookup2(input logic [0:0] idx, output logic vv, output logic [1:0] vw);
        @(negedge clk);
        lk_valid2 = 1'b1; lk_idx2 = idx;
        @(negedge clk);
        lk_valid2 = 1'b0;
        vv = vv2; vw = vw2;
    endtask

    task automatic test_reset();
        logic       vv;
        logic [3:0] vw;
        resetn = 1'b0;
        lk_valid4 = 0; lk_idx4 = '0; tc_valid4 = 0; tc_idx4 = '0; tc_way4 = '0;
        lk_valid2 = 0; lk_idx2 = '0; tc_valid2 = 0; tc_idx2 = '0; tc_way2 = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({vv4, vw4} !== 5'b0_0001) begin
            n_fail++; $display("FAIL reset4: got valid=%b way=%b, expected valid=0 way=0001", vv4, vw4);
        end
        n_cmp++;
        if ({vv2, vw2} !== 3'b0_01) begin
            n_fail++; $display("FAIL reset2: got valid=%b way=%b, expected valid=0 way=01", vv2, vw2);
        end
        resetn = 1'b1;
        lookup4(6'd0, vv, vw);
        n_cmp++;
        if ({vv, vw} !== 5'b1_0001) begin
            n_fail++; $display("FAIL first_lookup: got valid=%b way=%b, expected valid=1 way=0001", vv, vw);
        end
        @(negedge clk);
        n_cmp++;
        if (vv4 !== 1'b0) begin
            n_fail++; $display("FAIL valid_pulse: got valid=%b, expected 0", vv4);
        end
    endtask

    task automatic test_touch_sequence();
        logic       vv;
        logic [3:0] vw;
        logic [3:0] ways [3];
        logic [3:0] exps [3];
        ways = '{4'b0001, 4'b0100, 4'b0010};
        exps = '{4'b0100, 4'b0010, 4'b1000};
        for (int i = 0; i < 3; i++) begin
            touch4(6'd0, ways[i]);
            lookup4(6'd0, vv, vw);
            n_cmp++;
            if ({vv, vw} !== {1'b1, exps[i]}) begin
                n_fail++; $display("FAIL touch_seq[%0d]: got valid=%b way=%b, expected valid=1 way=%b", i, vv, vw, exps[i]);
            end
        end
    endtask

    task automatic test_independent_sets();
        logic       vv;
        logic [3:0] vw;
        touch4(6'd5, 4'b0001);
        lookup4(6'd6, vv, vw);
        n_cmp++;
        if (vw !== 4'b0001) begin
            n_fail++; $display("FAIL set_indep: got way=%b, expected 0001", vw);
        end
        touch4(6'd5, 4'b0000);
        lookup4(6'd5, vv, vw);
        n_cmp++;
        if (vw !== 4'b0100) begin
            n_fail++; $display("FAIL zero_touch: got way=%b, expected 0100", vw);
        end
        touch4(6'd5, 4'b0110);
        lookup4(6'd5, vv, vw);
        n_cmp++;
        if (vw !== 4'b0100) begin
            n_fail++; $display("FAIL multi_hot: got way=%b, expected 0100", vw);
        end
        lookup4(6'd0, vv, vw);
        n_cmp++;
        if (vw !== 4'b1000) begin
            n_fail++; $display("FAIL set0_kept: got way=%b, expected 1000", vw);
        end
    endtask

    task automatic test_same_cycle();
        logic       vv;
        logic [3:0] vw;
        @(negedge clk);
        tc_valid4 = 1'b1; tc_idx4 = 6'd3; tc_way4 = 4'b0001;
        lk_valid4 = 1'b1; lk_idx4 = 6'd3;
        @(negedge clk);
        tc_valid4 = 1'b0; tc_way4 = '0; lk_valid4 = 1'b0;
        n_cmp++;
        if ({vv4, vw4} !== {1'b1, EXP_SAME_CYCLE}) begin
            n_fail++; $display("FAIL same_idx: got valid=%b way=%b, expected valid=1 way=%b", vv4, vw4, EXP_SAME_CYCLE);
        end
        lookup4(6'd3, vv, vw);
        n_cmp++;
        if (vw !== 4'b0100) begin
            n_fail++; $display("FAIL same_idx_next: got way=%b, expected 0100", vw);
        end
        @(negedge clk);
        tc_valid4 = 1'b1; tc_idx4 = 6'd7; tc_way4 = 4'b0001;
        lk_valid4 = 1'b1; lk_idx4 = 6'd8;
        @(negedge clk);
        tc_valid4 = 1'b0; tc_way4 = '0; lk_valid4 = 1'b0;
        n_cmp++;
        if (vw4 !== 4'b0001) begin
            n_fail++; $display("FAIL diff_idx: got way=%b, expected 0001", vw4);
        end
        lookup4(6'd7, vv, vw);
        n_cmp++;
        if (vw !== 4'b0100) begin
            n_fail++; $display("FAIL diff_idx_touch: got way=%b, expected 0100", vw);
        end
    endtask

    task automatic test_back_to_back();
        logic       vv;
        logic [1:0] vw;
        logic [1:0] exp2;
        int         n_valid;
        @(negedge clk);
        lk_valid4 = 1'b1; lk_idx4 = 6'd0;
        @(negedge clk);
        n_cmp++;
        if ({vv4, vw4} !== 5'b1_1000) begin
            n_fail++; $display("FAIL b2b_first: got valid=%b way=%b, expected valid=1 way=1000", vv4, vw4);
        end
        lk_idx4 = 6'd5;
        @(negedge clk);
        lk_valid4 = 1'b0;
        n_cmp++;
        if ({vv4, vw4} !== 5'b1_0100) begin
            n_fail++; $display("FAIL b2b_second: got valid=%b way=%b, expected valid=1 way=0100", vv4, vw4);
        end
        for (int i = 0; i < 4; i++) begin
            touch2(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
            exp2 = (i % 2 == 0) ? 2'b10 : 2'b01;
            lookup2(1'b1, vv, vw);
            n_cmp++;
            if ({vv, vw} !== {1'b1, exp2}) begin
                n_fail++; $display("FAIL alt2[%0d]: got valid=%b way=%b, expected valid=1 way=%b", i, vv, vw, exp2);
            end
        end
        n_valid = 0;
        @(negedge clk);
        lk_valid2 = 1'b1; lk_idx2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vv2 === 1'b1) n_valid++;
        end
        lk_valid2 = 1'b0;
        n_cmp++;
        if (n_valid !== 8) begin
            n_fail++; $display("FAIL b2b8: got %0d valid cycles, expected 8", n_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (vv2 !== 1'b0) begin
            n_fail++; $display("FAIL b2b8_end: got valid=%b, expected 0", vv2);
        end
    endtask

    task automatic test_reset_midstream();
        logic       vv;
        logic [3:0] vw;
        logic [5:0] idxs [3];
        idxs = '{6'd0, 6'd3, 6'd5};
        @(negedge clk);
        lk_valid4 = 1'b1; lk_idx4 = 6'd3;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 resetn = 1'b1;
        lk_valid4 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({vv4, vw4} !== 5'b0_0001) begin
            n_fail++; $display("FAIL mid_reset: got valid=%b way=%b, expected valid=0 way=0001", vv4, vw4);
        end
        touch4(6'd3, 4'b0001);
        @(negedge clk);
        lk_valid4 = 1'b1; lk_idx4 = 6'd3; resetn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({vv4, vw4} !== 5'b0_0001) begin
            n_fail++; $display("FAIL held_reset: got valid=%b way=%b, expected valid=0 way=0001", vv4, vw4);
        end
        lk_valid4 = 1'b0; resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lookup4(idxs[i], vv, vw);
            n_cmp++;
            if ({vv, vw} !== 5'b1_0001) begin
                n_fail++; $display("FAIL post_reset[%0d]: got valid=%b way=%b, expected valid=1 way=0001", idxs[i], vv, vw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_touch_sequence();
        test_independent_sets();
        test_back_to_back();
        test_same_cycle();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
